// File: rtl/tank_life_ctrl_pkg.sv
// Shared definitions for the tank life-cycle controller and the score/LED display logic.
// Provides the state encoding (S_IDLE..S_DEAD), the typed state enum built on it and
// the width of the lives counter.
package tank_life_ctrl_pkg;

  localparam int unsigned LIVES_W = 3;
  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] S_IDLE    = 3'd0;
  localparam logic [STATE_W-1:0] S_ALIVE   = 3'd1;
  localparam logic [STATE_W-1:0] S_BURST   = 3'd2;
  localparam logic [STATE_W-1:0] S_RESPAWN = 3'd3;
  localparam logic [STATE_W-1:0] S_INVULN  = 3'd4;
  localparam logic [STATE_W-1:0] S_DEAD    = 3'd5;

  typedef enum logic [STATE_W-1:0] {
    StIdle    = S_IDLE,
    StAlive   = S_ALIVE,
    StBurst   = S_BURST,
    StRespawn = S_RESPAWN,
    StInvuln  = S_INVULN,
    StDead    = S_DEAD
  } tank_state_e;

endpackage

// File: rtl/tank_life_ctrl_cycle_timer.sv
// Loadable 32-bit down-counter used to time the burst, respawn and invulnerable states.
// Ports:
//   clock     in   system clock
//   reset     in   synchronous, active-high reset
//   load      in   load load_val and arm the counter (wins over counting)
//   load_val  in   32-bit start value; the counter runs load_val+1 cycles
//   done      out  one-cycle pulse when the armed count reaches 0
// Once done fires the counter disarms and holds, so it never free-runs.
module tank_life_ctrl_cycle_timer (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] load_val,
  output logic        done
);

  logic [31:0] count_q;
  logic        armed_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
      armed_q <= 1'b0;
    end else if (load) begin
      count_q <= load_val;
      armed_q <= 1'b1;
    end else if (armed_q) begin
      if (count_q == '0) begin
        armed_q <= 1'b0;
      end else begin
        count_q <= count_q - 32'd1;
      end
    end
  end

  assign done = armed_q && (count_q == '0);

endmodule

// File: rtl/tank_life_ctrl.sv
// Per-tank life-cycle sequencer: hit -> burst sprite -> rojobot reset pulse -> invulnerable
// window -> alive again, with a lives counter and a game-over state.
// Ports:
//   clock      in   system clock
//   reset      in   synchronous, active-high reset (overrides everything)
//   start      in   begin a new game; honoured in IDLE and DEAD only
//   hit        in   tank hit (level or pulse); honoured in ALIVE only
//   burst      out  icon shows burst sprite
//   bot_reset  out  rojobot reset pulse
//   invuln     out  hits ignored (INVULN state)
//   visible    out  renderer should draw the tank
//   lives      out  lives remaining
//   game_over  out  high in DEAD
//   state      out  current state code, for debug/LEDs
// Build option: define INVULN_BLINK_EN to blink visible every BLINK_CYCLES during INVULN.
// All outputs are registered from the next state, so they track the state register.
module tank_life_ctrl
  import tank_life_ctrl_pkg::*;
#(
  parameter int unsigned BURST_CYCLES  = 32'h300_0000,
  parameter int unsigned RESET_PULSE   = 16,
  parameter int unsigned INVULN_CYCLES = 25_000_000,
  parameter int unsigned BLINK_CYCLES  = 3_125_000,
  parameter int unsigned LIVES         = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               hit,
  output logic               burst,
  output logic               bot_reset,
  output logic               invuln,
  output logic               visible,
  output logic [LIVES_W-1:0] lives,
  output logic               game_over,
  output logic [STATE_W-1:0] state
);

  if (LIVES < 1 || LIVES > 7 || BLINK_CYCLES < 1) begin : g_param_check
    $error("tank_life_ctrl: LIVES must be 1..7 and BLINK_CYCLES nonzero");
  end

  // Timer reload values: a state lasting N cycles loads N-1 and exits on done.
  localparam logic [31:0] BurstLoad  = 32'(BURST_CYCLES - 1);
  localparam logic [31:0] PulseLoad  = 32'(RESET_PULSE - 1);
  localparam logic [31:0] InvulnLoad = 32'(INVULN_CYCLES - 1);
  localparam logic [LIVES_W-1:0] LivesInit = LIVES_W'(LIVES);

  tank_state_e        state_q, state_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic               burst_q, bot_reset_q, invuln_q, visible_q, game_over_q;
  logic               visible_base, visible_d;
  logic               timer_load, timer_done;
  logic [31:0]        timer_val;

  tank_life_ctrl_cycle_timer u_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (timer_load),
    .load_val (timer_val),
    .done     (timer_done)
  );

  always_comb begin
    state_d    = state_q;
    lives_d    = lives_q;
    timer_load = 1'b0;
    timer_val  = '0;
    case (state_q)
      StIdle, StDead: begin
        if (start) begin
          state_d = StAlive;
          lives_d = LivesInit;
        end
      end
      StAlive: begin
        // Hit wins over a simultaneous start; start is not honoured here anyway.
        if (hit) begin
          state_d    = StBurst;
          lives_d    = lives_q - LIVES_W'(1);
          timer_load = 1'b1;
          timer_val  = BurstLoad;
        end
      end
      StBurst: begin
        if (timer_done) begin
          if (lives_q == '0) begin
            state_d = StDead;
          end else begin
            state_d    = StRespawn;
            timer_load = 1'b1;
            timer_val  = PulseLoad;
          end
        end
      end
      StRespawn: begin
        if (timer_done) begin
          state_d    = StInvuln;
          timer_load = 1'b1;
          timer_val  = InvulnLoad;
        end
      end
      StInvuln: begin
        if (timer_done) begin
          state_d = StAlive;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign visible_base = (state_d == StAlive) || (state_d == StBurst) ||
                        (state_d == StRespawn) || (state_d == StInvuln);

`ifdef INVULN_BLINK_EN
  localparam logic [31:0] BlinkLast = 32'(BLINK_CYCLES - 1);

  logic [31:0] blink_cnt_q, blink_cnt_d;
  logic        blink_vis_q, blink_vis_d;

  // Counter sits at 0 with vis=1 outside INVULN, which gives the clear-on-entry
  // and show-on-entry behaviour for free.
  always_comb begin
    blink_cnt_d = '0;
    blink_vis_d = 1'b1;
    if ((state_d == StInvuln) && (state_q == StInvuln)) begin
      if (blink_cnt_q == BlinkLast) begin
        blink_cnt_d = '0;
        blink_vis_d = ~blink_vis_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 32'd1;
        blink_vis_d = blink_vis_q;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      blink_cnt_q <= '0;
      blink_vis_q <= 1'b1;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_vis_q <= blink_vis_d;
    end
  end

  assign visible_d = (state_d == StInvuln) ? blink_vis_d : visible_base;
`else
  assign visible_d = visible_base;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      lives_q     <= '0;
      burst_q     <= 1'b0;
      bot_reset_q <= 1'b0;
      invuln_q    <= 1'b0;
      visible_q   <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      burst_q     <= (state_d == StBurst);
      bot_reset_q <= (state_d == StRespawn);
      invuln_q    <= (state_d == StInvuln);
      visible_q   <= visible_d;
      game_over_q <= (state_d == StDead);
    end
  end

  assign burst     = burst_q;
  assign bot_reset = bot_reset_q;
  assign invuln    = invuln_q;
  assign visible   = visible_q;
  assign lives     = lives_q;
  assign game_over = game_over_q;
  assign state     = state_q;

endmodule
